// File: rtl/divider_ctrl.sv
// Programmable clock divider with start/stop control and a ready/valid config port.
// Config written in IDLE takes effect at once; config written in RUN is held in a
// shadow register and swapped in at the next period wrap so periods never tear.
module divider_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEF_DIV  = 10,
  parameter int unsigned DEF_HIGH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] sh_div_q, sh_div_d;
  logic [WIDTH-1:0] sh_high_q, sh_high_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             cfg_err_q, cfg_err_d;

  logic cfg_fire;
  logic cfg_legal;
  logic at_end;

  assign at_end    = (cnt_q == div_q - WIDTH'(1));
  // N >= 2 and 1 <= H <= N-1
  assign cfg_legal = (cfg_div >= WIDTH'(2)) && (cfg_high != '0) && (cfg_high < cfg_div);
  assign cfg_fire  = cfg_valid && cfg_ready;

  assign cnt     = cnt_q;
  assign clk_out = clk_out_q;
  assign cfg_err = cfg_err_q;
  assign busy    = (state_q != StIdle);
  assign tick    = (state_q != StIdle) && at_end;

  // Ready: always in IDLE, in RUN only while no shadow config is waiting, never in DRAIN.
  always_comb begin
    cfg_ready = 1'b0;
    unique case (state_q)
      StIdle:  cfg_ready = 1'b1;
      StRun:   cfg_ready = !pending_q;
      default: cfg_ready = 1'b0;
    endcase
  end

  // Next-state logic for the FSM, counter, config registers and error pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    high_d    = high_q;
    sh_div_d  = sh_div_q;
    sh_high_d = sh_high_q;
    pending_d = pending_q;
    cfg_err_d = cfg_fire && !cfg_legal;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cfg_fire && cfg_legal) begin
          div_d  = cfg_div;
          high_d = cfg_high;
        end
        // stop wins over start
        if (start && !stop) begin
          state_d = StRun;
        end
      end
      StRun, StDrain: begin
        if (state_q == StRun && cfg_fire && cfg_legal) begin
          sh_div_d  = cfg_div;
          sh_high_d = cfg_high;
          pending_d = 1'b1;
        end
        if (at_end) begin
          cnt_d = '0;
          // pending_q and a fresh accept are mutually exclusive (ready is low while pending)
          if (pending_q) begin
            div_d     = sh_div_q;
            high_d    = sh_high_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        if (state_q == StRun) begin
          if (stop) begin
            state_d = at_end ? StIdle : StDrain;
          end
        end else if (at_end) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // A config accepted on the last RUN edge must not be lost when dropping to IDLE.
    if (state_d == StIdle && pending_d) begin
      div_d     = sh_div_d;
      high_d    = sh_high_d;
      pending_d = 1'b0;
    end

    clk_out_d = (state_d != StIdle) && (cnt_d < high_d);
  end

  // State register; reset also discards any shadow config.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= WIDTH'(DEF_DIV);
      high_q    <= WIDTH'(DEF_HIGH);
      sh_div_q  <= WIDTH'(DEF_DIV);
      sh_high_q <= WIDTH'(DEF_HIGH);
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      sh_div_q  <= sh_div_d;
      sh_high_q <= sh_high_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: hand sequences for defaults, drain, mid-run
// reconfig and async reset, then a table of IDLE config writes each verified by
// measuring one full output period against a queue of expected N/H pairs.
module tb_divider_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       clk_out;
  logic       tick;
  logic [7:0] cnt;
  logic       busy;
  logic       cfg_err;

  int total;
  int bad;

  typedef struct {
    logic [7:0] div;
    logic [7:0] high;
    logic       err;
  } vec_t;

  typedef struct {
    int n;
    int h;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  divider_ctrl #(
    .WIDTH    (8),
    .DEF_DIV  (10),
    .DEF_HIGH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .clk_out   (clk_out),
    .tick      (tick),
    .cnt       (cnt),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start from IDLE, measure one period, compare with the scoreboard head, stop at tick.
  task automatic run_period();
    int   len;
    int   hi;
    bit   seen;
    exp_t e;
    len  = 0;
    hi   = 0;
    seen = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_cnt", int'(cnt), 0);
    chk("first_clk_out", int'(clk_out), 1);
    for (int k = 0; k < 300; k++) begin
      len++;
      if (clk_out) hi++;
      if (tick) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("tick_seen", int'(seen), 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("period_len", len, e.n);
      chk("period_high", hi, e.h);
      chk("tick_cnt", int'(cnt), e.n - 1);
    end
    // stop on the last cycle goes straight to IDLE
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_end_busy", int'(busy), 0);
    chk("stop_end_cnt", int'(cnt), 0);
    chk("stop_end_clk_out", int'(clk_out), 0);
  endtask

  initial begin
    int exp_n;
    int exp_h;
    exp_t e;

    vecs[0] = '{div: 8'd5,  high: 8'd5,  err: 1'b1};
    vecs[1] = '{div: 8'd4,  high: 8'd1,  err: 1'b0};
    vecs[2] = '{div: 8'd1,  high: 8'd1,  err: 1'b1};
    vecs[3] = '{div: 8'd2,  high: 8'd1,  err: 1'b0};
    vecs[4] = '{div: 8'd6,  high: 8'd0,  err: 1'b1};
    vecs[5] = '{div: 8'd7,  high: 8'd3,  err: 1'b0};
    vecs[6] = '{div: 8'd0,  high: 8'd0,  err: 1'b1};
    vecs[7] = '{div: 8'd3,  high: 8'd2,  err: 1'b0};
    vecs[8] = '{div: 8'd12, high: 8'd11, err: 1'b0};
    vecs[9] = '{div: 8'd9,  high: 8'd12, err: 1'b1};

    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_high  = 8'd0;

    // reset state
    #12;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle_cnt", int'(cnt), 0);

    // defaults: 10-cycle period, 5 high; start held high is a no-op in RUN
    start = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      chk("def_cnt", int'(cnt), i % 10);
      chk("def_clk_out", int'(clk_out), (i % 10) < 5 ? 1 : 0);
      chk("def_tick", int'(tick), (i % 10) == 9 ? 1 : 0);
      chk("def_busy", int'(busy), 1);
      step();
    end

    // graceful stop at cnt=2; start still high must be ignored in DRAIN
    step();
    step();
    chk("drain_pre_cnt", int'(cnt), 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int c = 3; c < 10; c++) begin
      chk("drain_cnt", int'(cnt), c);
      chk("drain_busy", int'(busy), 1);
      chk("drain_ready", int'(cfg_ready), 0);
      chk("drain_tick", int'(tick), c == 9 ? 1 : 0);
      step();
    end
    chk("drain_idle_busy", int'(busy), 0);
    chk("drain_idle_clk_out", int'(clk_out), 0);
    chk("drain_idle_cnt", int'(cnt), 0);

    // start still high: RUN again, then reconfig at cnt=3
    step();
    start = 1'b0;
    chk("rerun_cnt", int'(cnt), 0);
    step();
    step();
    step();
    chk("recfg_cnt", int'(cnt), 3);
    chk("recfg_ready", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    cfg_high  = 8'd1;
    step();
    cfg_valid = 1'b0;
    for (int c = 4; c < 10; c++) begin
      chk("old_cnt", int'(cnt), c);
      chk("old_ready", int'(cfg_ready), 0);
      chk("old_clk_out", int'(clk_out), c < 5 ? 1 : 0);
      chk("old_tick", int'(tick), c == 9 ? 1 : 0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      chk("new_cnt", int'(cnt), i % 4);
      chk("new_clk_out", int'(clk_out), (i % 4) == 0 ? 1 : 0);
      chk("new_tick", int'(tick), (i % 4) == 3 ? 1 : 0);
      chk("new_ready", int'(cfg_ready), 1);
      step();
    end

    // async reset mid-RUN with a pending config
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    cfg_high  = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready", int'(cfg_ready), 0);
    chk("pend_busy", int'(busy), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    e.n = 10;
    e.h = 5;
    sb.push_back(e);
    run_period();

    // start and stop together in IDLE: stays IDLE
    start = 1'b1;
    stop  = 1'b1;
    step();
    chk("both_busy0", int'(busy), 0);
    step();
    chk("both_busy1", int'(busy), 0);
    chk("both_cnt", int'(cnt), 0);
    start = 1'b0;
    stop  = 1'b0;

    // config table in IDLE
    exp_n = 10;
    exp_h = 5;
    for (int v = 0; v < 10; v++) begin
      chk("tbl_ready", int'(cfg_ready), 1);
      cfg_valid = 1'b1;
      cfg_div   = vecs[v].div;
      cfg_high  = vecs[v].high;
      step();
      cfg_valid = 1'b0;
      chk("tbl_err_pulse", int'(cfg_err), int'(vecs[v].err));
      step();
      chk("tbl_err_clear", int'(cfg_err), 0);
      if (!vecs[v].err) begin
        exp_n = int'(vecs[v].div);
        exp_h = int'(vecs[v].high);
      end
      e.n = exp_n;
      e.h = exp_h;
      sb.push_back(e);
      run_period();
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
